// File: rtl/drawline_if.sv
// Span rasteriser bus bundle: span handshake from calcline plus the frameblock Z read and pixel write ports.
// master = drawline side; slave = span source / frameblock side.
interface drawline_if;
    logic [248:0] span_data;
    logic         span_start;
    logic         span_done;
    logic         zrd_en;
    logic [9:0]   zrd_addr;
    logic [15:0]  zrd_data;
    logic         pix_we;
    logic [9:0]   pix_addr;
    logic [15:0]  pix_rgb;
    logic [15:0]  pix_z;

    modport master (
        input  span_data, span_start, zrd_data,
        output span_done, zrd_en, zrd_addr,
        output pix_we, pix_addr, pix_rgb, pix_z
    );

    modport slave (
        output span_data, span_start, zrd_data,
        input  span_done, zrd_en, zrd_addr,
        input  pix_we, pix_addr, pix_rgb, pix_z
    );
endinterface

// File: rtl/drawline.sv
// drawline: vertical span rasteriser with Z test, 1 pixel/clk (stage 1 Z read, stage 2 compare/write).
// Ports: clk, rst_n (sync, active low), bus (drawline_if.master: span in, Z read, pixel write).

// One attribute accumulator step: c + nc, nc is one bit wider and signed.
module drawline_acc #(
    parameter int W     = 24,
    parameter bit CLAMP = 1'b1
) (
    input  logic [W-1:0] c,
    input  logic [W:0]   n,
    output logic [W-1:0] s
);
    // Two guard bits: enough for both the carry past max and the sign.
    logic signed [W+1:0] sum;
    logic                top_unused;

    assign sum = $signed({2'b00, c}) + $signed({n[W], n});
    assign top_unused = ^sum[W+1:W];

    always_comb begin
        s = sum[W-1:0];
        if (CLAMP) begin
            if (sum[W+1])
                s = '0;
            else if (sum[W])
                s = '1;
        end
    end
endmodule

module drawline #(
    parameter bit Z_TEST = 1'b1,
    parameter bit CLAMP  = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    drawline_if.master bus
);
    typedef struct packed {
        logic [7:0]  y_start;
        logic [7:0]  y_end;
        logic [2:0]  x;
        logic        pad_z;
        logic [23:0] z;
        logic [24:0] nz;
        logic        pad_r;
        logic [13:0] r;
        logic [14:0] nr;
        logic        pad_g;
        logic [14:0] g;
        logic [15:0] ng;
        logic        pad_b;
        logic [13:0] b;
        logic [14:0] nb;
        logic        pad_u;
        logic [20:0] u;
        logic [21:0] nu;
        logic        pad_v;
        logic [20:0] v;
        logic [21:0] nv;
    } span_t;

    typedef struct packed {
        logic        vld;
        logic [9:0]  addr;
        logic [15:0] rgb;
        logic [15:0] z;
    } pipe_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state_q, state_d;
    span_t  sp;
    pipe_t  pipe_q;
    logic   latch, step, zpass;
    logic   span_unused;

    logic [7:0]  y_q, yend_q;
    logic [1:0]  x_q;
    logic [23:0] z_q, z_s;
    logic [24:0] nz_q;
    logic [13:0] r_q, r_s, b_q, b_s;
    logic [14:0] nr_q, nb_q;
    logic [14:0] g_q, g_s;
    logic [15:0] ng_q;
    logic [20:0] u_q, u_s, v_q, v_s;
    logic [21:0] nu_q, nv_q;

    assign sp = bus.span_data;

    // Frameblock is 4 columns wide, so x[2] never reaches an address.
    assign span_unused = ^{sp.pad_z, sp.pad_r, sp.pad_g,
                           sp.pad_b, sp.pad_u, sp.pad_v, sp.x[2]};

    drawline_acc #(.W(24), .CLAMP(CLAMP)) u_acc_z (.c(z_q), .n(nz_q), .s(z_s));
    drawline_acc #(.W(14), .CLAMP(CLAMP)) u_acc_r (.c(r_q), .n(nr_q), .s(r_s));
    drawline_acc #(.W(15), .CLAMP(CLAMP)) u_acc_g (.c(g_q), .n(ng_q), .s(g_s));
    drawline_acc #(.W(14), .CLAMP(CLAMP)) u_acc_b (.c(b_q), .n(nb_q), .s(b_s));
    drawline_acc #(.W(21), .CLAMP(CLAMP)) u_acc_u (.c(u_q), .n(nu_q), .s(u_s));
    drawline_acc #(.W(21), .CLAMP(CLAMP)) u_acc_v (.c(v_q), .n(nv_q), .s(v_s));

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.span_start) begin
                    latch   = 1'b1;
                    state_d = (sp.y_end >= sp.y_start) ? RUN : DRAIN;
                end
            end
            RUN: begin
                step = 1'b1;
                // Leave on y_end itself so y_end=255 never wraps to 0.
                if (y_q == yend_q)
                    state_d = DRAIN;
            end
            DRAIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are gated by rst_n so nothing is issued in the reset cycle.
    assign zpass         = pipe_q.z < bus.zrd_data;
    assign bus.span_done = (state_q == IDLE);
    assign bus.zrd_en    = Z_TEST && step && rst_n;
    assign bus.zrd_addr  = step ? {x_q, y_q} : 10'd0;
    assign bus.pix_we    = rst_n && pipe_q.vld && (!Z_TEST || zpass);
    assign bus.pix_addr  = pipe_q.addr;
    assign bus.pix_rgb   = pipe_q.rgb;
    assign bus.pix_z     = pipe_q.z;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pipe_q  <= '0;
            y_q     <= '0;
            yend_q  <= '0;
            x_q     <= '0;
            z_q     <= '0;
            nz_q    <= '0;
            r_q     <= '0;
            nr_q    <= '0;
            g_q     <= '0;
            ng_q    <= '0;
            b_q     <= '0;
            nb_q    <= '0;
            u_q     <= '0;
            nu_q    <= '0;
            v_q     <= '0;
            nv_q    <= '0;
        end else begin
            state_q    <= state_d;
            pipe_q.vld <= step;
            if (step) begin
                pipe_q.addr <= {x_q, y_q};
                pipe_q.rgb  <= {r_q[13:9], g_q[14:9], b_q[13:9]};
                pipe_q.z    <= {1'b0, z_q[23:9]};
            end
            if (latch) begin
                y_q    <= sp.y_start;
                yend_q <= sp.y_end;
                x_q    <= sp.x[1:0];
                z_q    <= sp.z;
                nz_q   <= sp.nz;
                r_q    <= sp.r;
                nr_q   <= sp.nr;
                g_q    <= sp.g;
                ng_q   <= sp.ng;
                b_q    <= sp.b;
                nb_q   <= sp.nb;
                u_q    <= sp.u;
                nu_q   <= sp.nu;
                v_q    <= sp.v;
                nv_q   <= sp.nv;
            end else if (step) begin
                y_q <= y_q + 8'd1;
                z_q <= z_s;
                r_q <= r_s;
                g_q <= g_s;
                b_q <= b_s;
                u_q <= u_s;
                v_q <= v_s;
            end
        end
    end
endmodule

// File: tb/tb_drawline.sv
// tb_drawline: table-driven spans with a pixel scoreboard, plus reset, busy and back-to-back sequences.
// dut has Z_TEST=1 against a Z memory model; dut2 (Z_TEST=0) sees the same spans.
module tb_drawline;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [248:0] span_data = '0;
    logic         span_start = 1'b0;
    logic [15:0]  zmem [1024];
    logic [15:0]  zrd_q = 16'h0;

    drawline_if dif();
    drawline_if dif2();

    assign dif.span_data   = span_data;
    assign dif.span_start  = span_start;
    assign dif.zrd_data    = zrd_q;
    assign dif2.span_data  = span_data;
    assign dif2.span_start = span_start;
    assign dif2.zrd_data   = 16'h0;

    always @(posedge clk)
        if (dif.zrd_en) zrd_q <= zmem[dif.zrd_addr];

    drawline #(.Z_TEST(1'b1), .CLAMP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(dif)
    );
    drawline #(.Z_TEST(1'b0), .CLAMP(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(dif2)
    );

    typedef struct {
        logic [7:0]  ys;
        logic [7:0]  ye;
        logic [2:0]  x;
        logic [23:0] z;
        logic [24:0] nz;
        logic [13:0] r;
        logic [14:0] nr;
        logic [14:0] g;
        logic [15:0] ng;
        logic [13:0] b;
        logic [14:0] nb;
        logic [15:0] zfill;
        int          exp_writes;
        int          exp_done;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] rgb;
        logic [15:0] z;
    } pix_t;

    pix_t sb[$];
    pix_t mon_e;
    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int zrd_cnt = 0;
    int wr2_cnt = 0;
    int zrd2_cnt = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Saturating add; n is a (w+1)-bit two's complement increment.
    function automatic longint acc(input longint c, input logic [24:0] n,
                                   input int w);
        longint mx, ns, s;
        mx = (longint'(1) << w) - 1;
        ns = longint'(n) & ((longint'(1) << (w + 1)) - 1);
        if (ns > mx) ns = ns - (longint'(1) << (w + 1));
        s = c + ns;
        if (s < 0) s = 0;
        if (s > mx) s = mx;
        return s;
    endfunction

    always @(negedge clk) begin
        if (dif.zrd_en) zrd_cnt++;
        if (dif2.pix_we) wr2_cnt++;
        if (dif2.zrd_en) zrd2_cnt++;
        if (dif.pix_we) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pix_unexpected: write at addr %0h, required none",
                         dif.pix_addr);
            end else begin
                mon_e = sb.pop_front();
                check("pix", 64'({dif.pix_addr, dif.pix_rgb, dif.pix_z}),
                      64'({mon_e.addr, mon_e.rgb, mon_e.z}));
            end
        end
    end

    task automatic start_span(input vec_t v, output int n);
        longint z, r, g, b;
        pix_t   e;
        n = (v.ye >= v.ys) ? int'(v.ye) - int'(v.ys) + 1 : 0;
        for (int i = 0; i < n; i++)
            zmem[{v.x[1:0], 8'(int'(v.ys) + i)}] = v.zfill;
        z = longint'(v.z);
        r = longint'(v.r);
        g = longint'(v.g);
        b = longint'(v.b);
        for (int i = 0; i < n; i++) begin
            e.addr = {v.x[1:0], 8'(int'(v.ys) + i)};
            e.rgb  = {5'(r >> 9), 6'(g >> 9), 5'(b >> 9)};
            e.z    = 16'(z >> 9);
            if (e.z < v.zfill) sb.push_back(e);
            z = acc(z, v.nz, 24);
            r = acc(r, 25'(v.nr), 14);
            g = acc(g, 25'(v.ng), 15);
            b = acc(b, 25'(v.nb), 14);
        end
        span_data = {v.ys, v.ye, v.x, 1'b0, v.z, v.nz,
                     1'b0, v.r, v.nr, 1'b0, v.g, v.ng,
                     1'b0, v.b, v.nb,
                     1'b0, 21'($urandom), 22'($urandom),
                     1'b0, 21'($urandom), 22'($urandom)};
        span_start = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge where span_done is seen high.
    task automatic run_span(input vec_t v, input int busy_k, input string tag);
        int n, k, w0, zr0, w20, zr20;
        w0 = wr_cnt;
        zr0 = zrd_cnt;
        w20 = wr2_cnt;
        zr20 = zrd2_cnt;
        start_span(v, n);
        @(negedge clk);
        span_start = 1'b0;
        k = 1;
        check({tag, "_busy"}, 64'(dif.span_done), 64'(0));
        while (!dif.span_done && k < 600) begin
            @(negedge clk);
            k++;
            if (k == busy_k) begin
                span_start = 1'b1;
                span_data = ~span_data;
            end else begin
                span_start = 1'b0;
            end
        end
        span_start = 1'b0;
        check({tag, "_done_lat"}, 64'(k), 64'(v.exp_done));
        check({tag, "_writes"}, 64'(wr_cnt - w0), 64'(v.exp_writes));
        check({tag, "_zrd"}, 64'(zrd_cnt - zr0), 64'(v.exp_done - 2));
        check({tag, "_nz_writes"}, 64'(wr2_cnt - w20), 64'(v.exp_done - 2));
        check({tag, "_nz_zrd"}, 64'(zrd2_cnt - zr20), 64'(0));
        check({tag, "_sb_left"}, 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    vec_t vt[10];
    vec_t vb;
    vec_t va;
    int   n_rst;
    int   w_rst, zr_rst;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (zmem[i]) zmem[i] = 16'hFFFF;
        //          ys     ye     x     z            nz
        //          r          nr          g          ng
        //          b          nb          zfill      wr   done
        vt[0] = '{8'd3,   8'd6,   3'd5, 24'h020000, 25'h0,
                  14'h3E00, 15'h0,    15'h0,    16'h0,
                  14'h0,    15'h0,    16'hFFFF, 4,   6};
        vt[1] = '{8'd0,   8'd3,   3'd2, 24'h0,      25'h0,
                  14'h0,    15'h0200, 15'h0,    16'h0,
                  14'h0,    15'h0,    16'hFFFF, 4,   6};
        vt[2] = '{8'd0,   8'd3,   3'd2, 24'h0,      25'h0,
                  14'h0200, 15'h7E00, 15'h0,    16'h0,
                  14'h0,    15'h0,    16'hFFFF, 4,   6};
        vt[3] = '{8'd20,  8'd27,  3'd3, 24'h246800, 25'h0,
                  14'h1000, 15'h0,    15'h0,    16'h0,
                  14'h0,    15'h0,    16'h1234, 0,   10};
        vt[4] = '{8'd20,  8'd27,  3'd3, 24'h246800, 25'h0,
                  14'h1000, 15'h0,    15'h0,    16'h0,
                  14'h0,    15'h0,    16'h1235, 8,   10};
        vt[5] = '{8'd100, 8'd109, 3'd6, 24'h000400, 25'h1FFFE00,
                  14'h0,    15'h0,    15'h7E00, 16'h0300,
                  14'h3FFF, 15'h7E00, 16'hFFFF, 10,  12};
        vt[6] = '{8'd255, 8'd255, 3'd7, 24'h0,      25'h0,
                  14'h3FFF, 15'h0,    15'h0,    16'h0,
                  14'h0,    15'h0,    16'hFFFF, 1,   3};
        vt[7] = '{8'd9,   8'd8,   3'd1, 24'h0,      25'h0,
                  14'h0,    15'h0,    15'h0,    16'h0,
                  14'h0,    15'h0,    16'hFFFF, 0,   2};
        vt[8] = '{8'd0,   8'd255, 3'd0, 24'h0,      25'h1,
                  14'h0,    15'h0013, 15'h0,    16'h0007,
                  14'h0,    15'h0029, 16'hFFFF, 256, 258};
        vt[9] = '{8'd50,  8'd57,  3'd1, 24'h002000, 25'h0200,
                  14'h0,    15'h0,    15'h0,    16'h0,
                  14'h0,    15'h0,    16'h0014, 4,   10};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_done", 64'(dif.span_done), 64'(1));
        check("rst_we", 64'(dif.pix_we), 64'(0));
        check("rst_zrd_en", 64'(dif.zrd_en), 64'(0));
        check("rst_outs", 64'({dif.zrd_addr, dif.pix_addr,
                               dif.pix_rgb, dif.pix_z}), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", 64'(dif.span_done), 64'(1));

        for (int i = 0; i < 10; i++) begin
            run_span(vt[i], 0, $sformatf("row%0d", i));
            @(negedge clk);
        end

        // span_start while busy must not relatch or restart
        vb = '{8'd0, 8'd19, 3'd2, 24'h0, 25'h0,
               14'h1000, 15'h0040, 15'h0, 16'h0,
               14'h0, 15'h0, 16'hFFFF, 20, 22};
        run_span(vb, 3, "busy_ign");
        @(negedge clk);

        // Back-to-back: second start in the cycle span_done rises
        va = '{8'd30, 8'd33, 3'd3, 24'h0, 25'h0,
               14'h0, 15'h0200, 15'h0, 16'h0,
               14'h0, 15'h0, 16'hFFFF, 4, 6};
        vb = '{8'd60, 8'd62, 3'd1, 24'h0, 25'h0,
               14'h0, 15'h0, 15'h7FFF, 16'h0,
               14'h0, 15'h0, 16'hFFFF, 3, 5};
        run_span(va, 0, "b2b_a");
        run_span(vb, 0, "b2b_b");
        @(negedge clk);

        // Reset mid-RUN on span y 10..40
        vb = '{8'd10, 8'd40, 3'd1, 24'h0, 25'h0,
               14'h3E00, 15'h0, 15'h0, 16'h0,
               14'h0, 15'h0, 16'hFFFF, 31, 33};
        start_span(vb, n_rst);
        @(negedge clk);
        span_start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rstrun_cycle_we", 64'(dif.pix_we), 64'(0));
        check("rstrun_cycle_zrd", 64'(dif.zrd_en), 64'(0));
        w_rst = wr_cnt;
        zr_rst = zrd_cnt;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rstrun_done", 64'(dif.span_done), 64'(1));
        check("rstrun_we", 64'(dif.pix_we), 64'(0));
        check("rstrun_zrd_en", 64'(dif.zrd_en), 64'(0));
        sb.delete();
        repeat (50) @(negedge clk);
        check("rstrun_no_writes", 64'(wr_cnt - w_rst), 64'(0));
        check("rstrun_no_reads", 64'(zrd_cnt - zr_rst), 64'(0));
        check("rstrun_idle", 64'(dif.span_done), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
